// File: rtl/alu_muldiv_sequencer.sv
// alu_muldiv_sequencer: multi-cycle MUL (shift-add) / UDIV (restoring) controller
// driving an external combinational ALU, one ALU operation per cycle.
`default_nettype none

module alu_muldiv_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [4:0]       alu_FS,
  input  logic [WIDTH-1:0] alu_F,
  input  logic [3:0]       alu_status
);

  localparam logic [4:0]       FS_NOP  = 5'b00000;
  localparam logic [4:0]       FS_ADD  = 5'b01000;
  localparam logic [4:0]       FS_SUB  = 5'b01001;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Shared working registers: reg_a = acc/rem, reg_b = mc/quo, reg_c = mp/dvs
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] reg_a, reg_b, reg_c;
  logic [WIDTH-1:0] reg_a_d, reg_b_d, reg_c_d;
  logic [WIDTH-1:0] rem_sh;
  logic             div_ok;
  logic             last_iter;
  logic             unused_status;

  assign unused_status = ^{alu_status[3], alu_status[1:0]};
  assign rem_sh        = {reg_a[WIDTH-2:0], reg_b[WIDTH-1]};
  // A bit shifted out of rem means the shifted value exceeds any divisor
  assign div_ok        = alu_status[2] | reg_a[WIDTH-1];
  assign last_iter     = (cnt == CNT_END);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    alu_A   = '0;
    alu_B   = '0;
    alu_FS  = FS_NOP;
    reg_a_d = reg_a;
    reg_b_d = reg_b;
    reg_c_d = reg_c;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (op && (opB == '0)) ? DONE : RUN;
        end
      end
      RUN: begin
        if (op_q) begin
          alu_A   = rem_sh;
          alu_B   = reg_c;
          alu_FS  = FS_SUB;
          reg_a_d = div_ok ? alu_F : rem_sh;
          reg_b_d = {reg_b[WIDTH-2:0], div_ok};
        end else begin
          alu_A   = reg_a;
          alu_B   = reg_b;
          alu_FS  = FS_ADD;
          reg_a_d = reg_c[0] ? alu_F : reg_a;
          reg_b_d = {reg_b[WIDTH-2:0], 1'b0};
          reg_c_d = {1'b0, reg_c[WIDTH-1:1]};
        end
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= 1'b0;
      cnt       <= '0;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_c     <= '0;
      result    <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            cnt       <= '0;
            reg_a     <= '0;
            reg_b     <= opA;
            reg_c     <= opB;
            result    <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            if (op && (opB == '0)) begin
              remainder <= opA;
              div_zero  <= 1'b1;
            end
          end
        end
        RUN: begin
          reg_a <= reg_a_d;
          reg_b <= reg_b_d;
          reg_c <= reg_c_d;
          cnt   <= cnt + 1'b1;
          if (last_iter) begin
            result    <= op_q ? reg_b_d : reg_a_d;
            remainder <= op_q ? reg_a_d : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench for alu_muldiv_sequencer with a behavioural ALU and result scoreboard.
`default_nettype none

module tb_alu_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [63:0] opA = '0, opB = '0;
  logic        busy, done, div_zero;
  logic [63:0] result, remainder, alu_A, alu_B, alu_F;
  logic [4:0]  alu_FS;
  logic [3:0]  alu_status;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] rem;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  alu_muldiv_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .result(result), .remainder(remainder), .div_zero(div_zero),
    .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS), .alu_F(alu_F), .alu_status(alu_status)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: ADD, or SUB as A + ~B + 1
  logic [63:0] bsel;
  logic [64:0] sum;
  always_comb begin
    bsel = (alu_FS == 5'b01001) ? ~alu_B : alu_B;
    sum  = {1'b0, alu_A} + {1'b0, bsel} + ((alu_FS == 5'b01001) ? 65'd1 : 65'd0);
    alu_F = sum[63:0];
    alu_status = {(alu_A[63] == bsel[63]) && (sum[63] != alu_A[63]), sum[64],
                  sum[63:0] == 64'd0, sum[63]};
  end

  task automatic issue(input logic o, input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    e.dz  = o && (b == 64'd0);
    e.res = o ? ((b == 64'd0) ? 64'd0 : a / b) : a * b;
    e.rem = o ? ((b == 64'd0) ? a : a % b) : 64'd0;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Waits for done (bounded); optionally pulses a stray start at a given cycle.
  task automatic wait_done(input logic [4:0] exp_fs, input int pulse_at,
                           output int cycles, output int busy_cycles, output bit fs_ok);
    cycles = 0; busy_cycles = 0; fs_ok = 1'b1;
    while (cycles < 200) begin
      @(negedge clock);
      cycles++;
      if (cycles == pulse_at) begin
        start = 1'b1; opA = 64'd9; opB = 64'd9;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
      if (busy && !done && alu_FS !== exp_fs) fs_ok = 1'b0;
      if ((!busy || done) && alu_FS !== 5'b00000) fs_ok = 1'b0;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags busy=%b done=%b div_zero=%b required 0 0 0", busy, done, div_zero);
    end
    vectors++;
    if (result !== 64'd0 || remainder !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_result result=%h remainder=%h required 0 0", result, remainder);
    end
    vectors++;
    if (alu_A !== 64'd0 || alu_B !== 64'd0 || alu_FS !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_alu A=%h B=%h FS=%b required 0 0 00000", alu_A, alu_B, alu_FS);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    int cyc, bcyc; bit fs_ok; exp_t e;
    issue(1'b0, 64'd7, 64'd6);
    wait_done(5'b01000, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 65) begin
      miscompares++; $display("FAIL mul_latency got %0d required 65", cyc);
    end
    vectors++;
    if (bcyc !== 65) begin
      miscompares++; $display("FAIL mul_busy_cycles got %0d required 65", bcyc);
    end
    vectors++;
    if (result !== e.res || remainder !== e.rem || div_zero !== e.dz) begin
      miscompares++;
      $display("FAIL mul_7x6 got %h/%h/%b required %h/%h/%b", result, remainder, div_zero, e.res, e.rem, e.dz);
    end
    issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    wait_done(5'b01000, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (result !== e.res || e.res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++; $display("FAIL mul_wrap got %h required %h", result, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    vectors++;
    if (fs_ok !== 1'b1) begin
      miscompares++; $display("FAIL mul_fs got bad FS sequence required 01000 in RUN, 0 elsewhere");
    end
  endtask

  task automatic test_udiv();
    int cyc, bcyc; bit fs_ok; exp_t e;
    issue(1'b1, 64'd100, 64'd7);
    wait_done(5'b01001, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (result !== 64'd14 || remainder !== 64'd2 || div_zero !== 1'b0) begin
      miscompares++; $display("FAIL div_100_7 got %0d r%0d dz%b required 14 r2 dz0", result, remainder, div_zero);
    end
    vectors++;
    if (fs_ok !== 1'b1 || cyc !== 65) begin
      miscompares++; $display("FAIL div_fs_latency got fs_ok=%b lat=%0d required 1 65", fs_ok, cyc);
    end
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001);
    wait_done(5'b01001, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (result !== e.res || remainder !== e.rem || div_zero !== e.dz) begin
      miscompares++;
      $display("FAIL div_rem63 got %h r%h required %h r%h", result, remainder, e.res, e.rem);
    end
  endtask

  task automatic test_div_zero();
    int cyc, bcyc; bit fs_ok; exp_t e;
    issue(1'b1, 64'd5, 64'd0);
    wait_done(5'b01001, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (cyc !== 1 || bcyc !== 1) begin
      miscompares++; $display("FAIL divz_latency got lat=%0d busy=%0d required 1 1", cyc, bcyc);
    end
    vectors++;
    if (result !== 64'd0 || remainder !== 64'd5 || div_zero !== 1'b1 || e.dz !== 1'b1) begin
      miscompares++; $display("FAIL divz_result got %0d r%0d dz%b required 0 r5 dz1", result, remainder, div_zero);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, bcyc; bit fs_ok; exp_t e;
    issue(1'b0, 64'd3, 64'd4);
    wait_done(5'b01000, 10, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (result !== 64'd12 || cyc !== 65 || e.res !== 64'd12) begin
      miscompares++; $display("FAIL ignore_start got %0d lat=%0d required 12 65", result, cyc);
    end
    repeat (2) @(negedge clock);
    vectors++;
    if (result !== 64'd12 || busy !== 1'b0) begin
      miscompares++; $display("FAIL result_hold got %0d busy=%b required 12 0", result, busy);
    end
  endtask

  task automatic test_abort();
    int cyc, bcyc; bit fs_ok, seen_done; exp_t e;
    issue(1'b0, 64'd3, 64'd4);
    repeat (30) @(negedge clock);
    reset_n = 1'b0;
    #1;
    e = sb.pop_front();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || alu_FS !== 5'd0) begin
      miscompares++;
      $display("FAIL abort got busy=%b done=%b result=%0d FS=%b required 0 0 0 00000", busy, done, result, alu_FS);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    reset_n = 1'b1;
    repeat (70) begin
      @(negedge clock);
      if (done) seen_done = 1'b1;
    end
    vectors++;
    if (seen_done !== 1'b0) begin
      miscompares++; $display("FAIL abort_no_done got done=1 required 0");
    end
    issue(1'b0, 64'd2, 64'd2);
    wait_done(5'b01000, 0, cyc, bcyc, fs_ok);
    e = sb.pop_front();
    vectors++;
    if (result !== 64'd4 || cyc !== 65) begin
      miscompares++; $display("FAIL after_abort got %0d lat=%0d required 4 65", result, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc; bit fs_ok; exp_t e;
    logic [63:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> (i * 10);
      if (b == 64'd0) b = 64'd3;
      issue(i[0], a, b);
      wait_done(i[0] ? 5'b01001 : 5'b01000, 0, cyc, bcyc, fs_ok);
      e = sb.pop_front();
      vectors++;
      if (result !== e.res || remainder !== e.rem || div_zero !== e.dz || !fs_ok) begin
        miscompares++;
        $display("FAIL b2b_%0d got %h r%h dz%b fs_ok=%b required %h r%h dz%b",
                 i, result, remainder, div_zero, fs_ok, e.res, e.rem, e.dz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_udiv();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_muldiv_sequencer.md
Name: alu_muldiv_sequencer

Overview:
Multi-cycle controller that drives the 64-bit datapath ALU as its initiator. It issues A/B/FS each cycle and consumes F and status {V,C,Z,N} to compute a 64-bit MUL (low product) or a UDIV (quotient plus remainder). It uses iterative shift-add and restoring division, one ALU operation per cycle, and sits beside the ALU in the execute stage. The ALU is purely combinational, so F and status are sampled in the same cycle the sequencer drives A/B/FS.

Parameters:
WIDTH, 64, operand/result width; the iteration count equals WIDTH.
CNT_W, 6, iteration counter width (log2 WIDTH).

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = MUL, 1 = UDIV
opA  in  64  multiplicand / dividend
opB  in  64  multiplier / divisor
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse; result valid
result  out  64  low product (MUL) or quotient (UDIV)
remainder  out  64  UDIV remainder; 0 for MUL
div_zero  out  1  UDIV with opB == 0; valid with done
alu_A  out  64  ALU A operand
alu_B  out  64  ALU B operand
alu_FS  out  5  ALU function select
alu_F  in  64  ALU result
alu_status  in  4  {V,C,Z,N} from ALU

Behaviour:
- Reset (async, reset_n = 0): state = IDLE; busy, done, div_zero = 0; result, remainder, internal regs, cnt = 0; alu_A = alu_B = 0; alu_FS = 5'b00000. Reset mid-operation aborts immediately; no done is produced.
- FS encodings used: ADD = 5'b01000; SUB = 5'b01001 (B inverted, carry-in = 1). For SUB, C = 1 means no borrow. Outside RUN, alu_FS = 5'b00000 and alu_A = alu_B = 0.
- IDLE: on start = 1, latch op, opA, opB; set cnt = 0; clear div_zero.
  - UDIV with opB == 0: go to DONE with result = 0, remainder = opA, div_zero = 1.
  - Otherwise go to RUN.
- RUN MUL (regs acc = 0, mc = opA, mp = opB):
  - Drive alu_A = acc, alu_B = mc, FS = ADD.
  - At each edge: if mp[0], acc <= alu_F (carry out is discarded, modulo 2^64). mc <<= 1; mp >>= 1.
- RUN UDIV (regs rem = 0, quo = opA, dvs = opB):
  - Combinationally form rem_sh = {rem[62:0], quo[63]}. Drive alu_A = rem_sh, alu_B = dvs, FS = SUB.
  - ok = alu_status[2] (C) | rem[63]. The rem[63] term covers the 65th bit shifted out, where subtraction always fits.
  - ok = 1: rem <= alu_F; quo <= {quo[62:0], 1}.
  - ok = 0: rem <= rem_sh; quo <= {quo[62:0], 0}.
- Counting: cnt increments each RUN edge. The edge with cnt == WIDTH-1 performs the last iteration and moves to DONE.
- DONE: done = 1 for exactly one cycle; result/remainder are valid. Return to IDLE next edge. result, remainder, and div_zero hold until the next accepted start.
- Latency (start sampled at edge k):
  - Normal op: RUN occupies edges k+1..k+64; done is high in the cycle after edge k+64, i.e. 65 cycles after acceptance.
  - Divide by zero: done is high in the cycle after edge k.
- start while busy = 1 is ignored (not queued). start sampled in the DONE cycle is also ignored; the earliest re-accept is the IDLE cycle.
- V, Z, N from the ALU are unused; the status port is 4 bits for interface compatibility.

Test Plan:
- MUL opA = 7, opB = 6 -> done exactly 65 cycles after start edge; result = 42, remainder = 0, div_zero = 0; busy high 65 cycles.
- MUL opA = 64'hFFFF_FFFF_FFFF_FFFF, opB = 2 -> result = 64'hFFFF_FFFF_FFFF_FFFE (overflow wraps); alu_FS = 01000 throughout RUN.
- UDIV opA = 100, opB = 7 -> result = 14, remainder = 2; alu_FS = 01001 throughout RUN.
- UDIV opA = 64'hFFFF_FFFF_FFFF_FFFF, opB = 64'h8000_0000_0000_0001 -> result = 1, remainder = 64'h7FFF_FFFF_FFFF_FFFE (exercises the rem[63] path).
- UDIV opA = 5, opB = 0 -> done in the cycle after the start edge; result = 0, remainder = 5, div_zero = 1.
- Start MUL 3×4; pulse start with new operands at RUN cycle 10 (ignored) -> result = 12. Then start again and drop reset_n at RUN cycle 30 -> busy, done, result = 0 immediately and alu_FS = 0. After release, a new MUL 2×2 -> result = 4.
